mv_collector: RTL
=================

# mv_collector

Receiving end of the motion-vector stream produced by the motion-estimation core (`mv_valid`/`mv`/`mv_addr`). Collects the 64 per-block vectors of each frame into a ping-pong register bank, checks ordering and range, and hands a completed frame to the downstream motion-compensation stage through a random-access read port with a release handshake. Sits directly after the estimator's output stage.

## Interface
- `NUM_BLK`, 64: blocks per frame; fixed at 64 for the 6-bit address.
- `SR`, 3: search range; legal vector components are -SR..+SR.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mv_valid` in 1: vector strobe from the estimator.
- `mv` in 8: `[7:4]` dx and `[3:0]` dy, each 4-bit two's complement.
- `mv_addr` in 6: block index 0..63.
- `busy` out 1: write bank complete but cannot swap; incoming vectors are dropped.
- `frame_done` out 1: one-cycle pulse when a frame moves to the read bank.
- `frame_err` out 1: valid with `frame_done`; the frame had a duplicate, out-of-range or dropped vector.
- `frame_idx` out 4: count of completed frames, mod 16.
- `rd_en` in 1, `rd_addr` in 6: read request on the read bank.
- `rd_valid` out 1, `rd_dx` out 4, `rd_dy` out 4: read response.
- `rel` in 1: consumer releases the read bank.

## Operation
- Two banks of 64×8 bits. `wsel` selects the write bank. `rd_held` marks the read bank as owned by the consumer.
- Per write bank: a 64-bit `seen` bitmap and a sticky `err` bit.
- Accept when `mv_valid` is high and the state is FILL:
  - Write `mv` at `mv_addr` and set `seen[mv_addr]`.
  - If `seen[mv_addr]` was already set, set `err`; the last write wins.
  - If dx or dy lies outside -3..+3 (4..7 or -8..-4), store the value as-is and set `err`.
- Completion means `seen` is all ones, counting the write at the current edge.
- State machine:
  - FILL, completion and (`!rd_held` or `rel`): swap at that edge. Toggle `wsel`, set `rd_held`, clear `seen` and `err` of the new write bank, increment `frame_idx`, assert `frame_done`/`frame_err` in the next cycle. Stay in FILL.
  - FILL, completion and `rd_held` and `!rel`: go to WAIT.
  - WAIT: `busy` is 1. A `mv_valid` in WAIT is dropped and sets the pending frame's `err`. On `rel`, perform the same swap at that edge and return to FILL.
- `rel` with `!rd_held`: ignored. `rel` in FILL without completion: clears `rd_held` only.
- Read port:
  - `rd_en` with `rd_held` returns the read-bank entry at `rd_addr`.
  - `rd_en` with `!rd_held` gives `rd_valid`=0 and zero data.
  - A read in the same cycle as `rel` is still served from the old bank.
- Reset values:
  - All outputs 0.
  - `wsel`=0, `rd_held`=0, state FILL.
  - `seen` and `err` cleared in both banks.
  - Bank contents are not reset.

## Timing
- Vector write: takes effect at the sampling edge; no stall on `mv_valid` in FILL.
- `frame_done`: registered pulse, exactly one cycle, in the cycle after the swap edge. `frame_err` is coincident with it and 0 otherwise. `frame_idx` updates in the same cycle as `frame_done`.
- `busy`: registered; high from the cycle after entering WAIT through the cycle of the releasing edge.
- Read latency is 1 cycle. `rd_en`/`rd_addr` are sampled at edge N; `rd_valid`/`rd_dx`/`rd_dy` are valid for cycle N+1 only. Back-to-back reads give one response per cycle.
- Assertion of `rst` at any time aborts the partial frame and clears state immediately.

## Structure
- Shared package `mv_pkg`:
  - Constants `NUM_BLK`, `SR`, `MV_W`=8, `COMP_W`=4.
  - Field slices for dx/dy.
  - State encoding FILL/WAIT.
- One natural sub-module, `mv_bank`: a 64×8 register file with a write port, a registered read port, and the `seen` bitmap with an all-ones detect. It is instantiated twice.

## Test plan
- Clean frame: 64 vectors, addr 0..63 in order, `mv`=8'h00..8'h3F masked into range. Expect `frame_done`=1 one cycle after the edge capturing addr 63, `frame_err`=0 and `frame_idx`=1. Reading addr 5 returns the stored dx/dy with `rd_valid` in the next cycle.
- Duplicate: addr 10 sent twice (8'h12, then 8'h21) plus the other 63 addresses. Expect `frame_done`, `frame_err`=1, and addr 10 reads dx=2, dy=1.
- Range: `mv`=8'h4D (dx=4, dy=-3) at addr 0 in an otherwise clean frame. Expect `frame_err`=1 and stored value 8'h4D.
- Backpressure: complete frame 1 and do not `rel`; complete frame 2. Expect `busy`=1 and no `frame_done`. A vector sent during `busy` is dropped. Pulse `rel`: expect `frame_done` next cycle with `frame_err`=1, and `busy` falls.
- Simultaneous: `rel` on the same edge as frame 2's last vector. Expect a direct swap, `busy` never high, and `frame_done` next cycle.
- Reset mid-frame: 30 vectors, then `rst`. Expect all outputs 0. A subsequent full frame yields `frame_idx`=1 and `frame_err`=0.

Source files
------------

// File: rtl/mv_pkg.sv
// Shared constants, field helpers and state encoding for the motion-vector collector.
package mv_pkg;
    localparam int NUM_BLK = 64;
    localparam int SR      = 3;
    localparam int MV_W    = 8;
    localparam int COMP_W  = 4;
    localparam int AW      = $clog2(NUM_BLK);

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_e;

    function automatic logic [COMP_W-1:0] mv_dx(input logic [MV_W-1:0] v);
        return v[7:4];
    endfunction

    function automatic logic [COMP_W-1:0] mv_dy(input logic [MV_W-1:0] v);
        return v[3:0];
    endfunction

    // Component is two's complement; legal window is -SR..+SR.
    function automatic logic comp_ok(input logic [COMP_W-1:0] c);
        return (int'($signed(c)) >= -SR) && (int'($signed(c)) <= SR);
    endfunction
endpackage

// File: rtl/mv_bank.sv
// One 64x8 vector bank: write port, registered read port, seen bitmap with
// an all-ones detect that already includes the write at the current edge.
module mv_bank
    import mv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [MV_W-1:0] wdata,
    input  logic            clr,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [MV_W-1:0] rdata,
    output logic            seen_hit,
    output logic            full
);
    logic [MV_W-1:0]    mem_q [NUM_BLK];
    logic [NUM_BLK-1:0] seen_q, seen_d, seen_w;
    logic [MV_W-1:0]    rdata_q, rdata_d;

    always_comb begin
        seen_w = seen_q;
        if (we) seen_w[waddr] = 1'b1;
        seen_d  = clr ? '0 : seen_w;
        rdata_d = re ? mem_q[raddr] : rdata_q;
    end

    assign seen_hit = seen_q[waddr];
    assign full     = &seen_w;
    assign rdata    = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q  <= '0;
            rdata_q <= '0;
        end else begin
            seen_q  <= seen_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately left unreset; seen_q gates its meaning.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
endmodule

// File: rtl/mv_collector.sv
// Ping-pong collector for per-block motion vectors: fills one bank while the
// consumer reads the other, swapping on completion once the reader releases.
module mv_collector
    import mv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mv_valid,
    input  logic [MV_W-1:0]   mv,
    input  logic [AW-1:0]     mv_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [3:0]        frame_idx,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_valid,
    output logic [COMP_W-1:0] rd_dx,
    output logic [COMP_W-1:0] rd_dy,
    input  logic              rel
);
    state_e     state_q, state_d;
    logic       wsel_q, wsel_d, rd_held_q, rd_held_d, rsel_q, rsel_d;
    logic       busy_q, busy_d, done_q, done_d, ferr_q, ferr_d, rd_valid_q, rd_valid_d;
    logic [3:0] idx_q, idx_d;
    logic [1:0] err_q, err_d;

    logic [1:0]           b_we, b_clr, b_hit, b_full;
    logic [1:0][MV_W-1:0] b_rdata;
    logic                 accept, oor, complete, err_w, swap;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        mv_bank u_bank (
            .clk(clk), .rst(rst),
            .we(b_we[g]), .waddr(mv_addr), .wdata(mv), .clr(b_clr[g]),
            .re(rd_en), .raddr(rd_addr), .rdata(b_rdata[g]),
            .seen_hit(b_hit[g]), .full(b_full[g])
        );
    end

    always_comb begin
        accept   = mv_valid && (state_q == FILL);
        oor      = !comp_ok(mv_dx(mv)) || !comp_ok(mv_dy(mv));
        complete = b_full[wsel_q];
        // A vector arriving while stalled is lost, so the pending frame is flagged.
        err_w    = err_q[wsel_q] | (accept & (b_hit[wsel_q] | oor))
                 | (mv_valid & (state_q == WAIT));
        swap     = ((state_q == FILL) && complete && (!rd_held_q || rel))
                 || ((state_q == WAIT) && rel);

        b_we          = '0;
        b_we[wsel_q]  = accept;
        b_clr         = '0;
        err_d         = err_q;
        err_d[wsel_q] = err_w;
        wsel_d        = wsel_q;
        rd_held_d     = rd_held_q;
        idx_d         = idx_q;
        done_d        = 1'b0;
        ferr_d        = 1'b0;
        state_d       = state_q;

        if (rel) rd_held_d = 1'b0;
        if (swap) begin
            wsel_d          = !wsel_q;
            rd_held_d       = 1'b1;
            b_clr[!wsel_q]  = 1'b1;
            err_d[!wsel_q]  = 1'b0;
            idx_d           = idx_q + 4'd1;
            done_d          = 1'b1;
            ferr_d          = err_w;
            state_d         = FILL;
        end else if ((state_q == FILL) && complete) begin
            state_d = WAIT;
        end

        busy_d     = (state_d == WAIT);
        rd_valid_d = rd_en && rd_held_q;
        rsel_d     = !wsel_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            wsel_q     <= 1'b0;
            rd_held_q  <= 1'b0;
            rsel_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            idx_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            wsel_q     <= wsel_d;
            rd_held_q  <= rd_held_d;
            rsel_q     <= rsel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            rd_valid_q <= rd_valid_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = ferr_q;
    assign frame_idx  = idx_q;
    assign rd_valid   = rd_valid_q;
    assign rd_dx      = rd_valid_q ? mv_dx(b_rdata[rsel_q]) : '0;
    assign rd_dy      = rd_valid_q ? mv_dy(b_rdata[rsel_q]) : '0;
endmodule
